// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned,
// start/done handshake with busy held high for WIDTH cycles.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    cnt_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] remo_q;
    logic             dbzo_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    always_comb begin
        a_neg   = is_signed & dividend[WIDTH-1];
        b_neg   = is_signed & divisor[WIDTH-1];
        a_mag   = a_neg ? -dividend : dividend;
        b_mag   = b_neg ? -divisor : divisor;
        shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        diff    = shifted - {1'b0, dsr_q};
        qbit    = ~diff[WIDTH];
        rem_d   = qbit ? diff : shifted;
        // dvd_q doubles as the quotient register: quotient bits fill from the LSB.
        dvd_d   = {dvd_q[WIDTH-2:0], qbit};
        // With a zero divisor the remainder magnitude is |dividend|, so the
        // sign fix-up alone restores the original dividend.
        quo_fin = dbz_q ? '1 : (qneg_q ? -dvd_d : dvd_d);
        rem_fin = rneg_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbzo_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q   <= a_mag;
                        dsr_q   <= b_mag;
                        rem_q   <= '0;
                        cnt_q   <= CNT_INIT;
                        qneg_q  <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        dbz_q   <= (divisor == '0);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quo_q   <= quo_fin;
                        remo_q  <= rem_fin;
                        dbzo_q  <= dbz_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider at WIDTH = 32.
module tb_seq_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [31:0] sa;
        logic signed [31:0] sb_;
        sa  = a;
        sb_ = b;
        e.z = 1'b0;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else if (!sg) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            e.q = sa / sb_;
            e.r = sa % sb_;
        end
        return e;
    endfunction

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_quotient"}, quotient, e.q);
            chk({tag, "_remainder"}, remainder, e.r);
            chk({tag, "_dbz"}, 32'(div_by_zero), 32'(e.z));
        end
    endtask

    // Issue one operation and follow it to completion; optionally pulse a
    // second start mid-RUN that must be ignored.
    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic pulse_mid);
        int edges    = 0;
        int busy_cnt = 0;
        int overlap  = 0;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        sb.push_back(model(sg, a, b));
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                start     = 1'b0;
                is_signed = ~sg;
                dividend  = $urandom;
                divisor   = $urandom;
            end
            if (pulse_mid && edges == 5) begin
                start    = 1'b1;
                dividend = 32'd999;
                divisor  = 32'd1;
            end
            if (pulse_mid && edges == 6) start = 1'b0;
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
        end while (!done && edges < 100);
        chk({tag, "_latency"}, 32'(edges), 32'd33);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
        chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        check_result(tag);
        @(negedge clk);
        chk({tag, "_done_fall"}, 32'(done), 32'd0);
    endtask

    task automatic wait_done(output int at_cyc, output logic seen);
        int n = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        at_cyc = cyc;
    endtask

    initial begin
        int   c1;
        int   c2;
        int   dcount;
        logic seen;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        run_op("u100_7",     1'b0, 32'd100, 32'd7, 1'b0);
        run_op("s_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("s_7_m2",     1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("u_fff9_2",   1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("u_dbz",      1'b0, 32'h1234, 32'd0, 1'b0);
        run_op("s_dbz",      1'b1, 32'h1234, 32'd0, 1'b0);
        run_op("s_dbz_neg",  1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op("s_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mid_pulse",  1'b0, 32'd1000, 32'd3, 1'b1);
        run_op("u_max_1",    1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Back-to-back with start held high; operands change after acceptance.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd6;
        sb.push_back(model(1'b0, 32'd50, 32'd6));
        @(posedge clk);
        @(negedge clk);
        is_signed = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
        sb.push_back(model(1'b1, 32'hFFFF_FF9C, 32'd7));
        wait_done(c1, seen);
        chk("b2b_first_done", 32'(seen), 32'd1);
        check_result("b2b_first");
        wait_done(c2, seen);
        start = 1'b0;
        chk("b2b_second_done", 32'(seen), 32'd1);
        check_result("b2b_second");
        chk("b2b_interval", 32'(c2 - c1), 32'd34);
        repeat (3) @(negedge clk);

        // Reset in the middle of RUN aborts without a done pulse.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("abort_no_activity", 32'(dcount), 32'd0);

        run_op("after_abort_5_5", 1'b0, 32'd5, 32'd5, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring integer divider for the pipeline CPU's execute stage. It computes one quotient bit per clock using repeated trial subtraction, which makes it the inverse datapath of the adder chain. It accepts one signed or unsigned operation at a time through a start/done handshake. The hazard unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width; legal range ≥ 2.
- `clk` input 1: rising-edge clock, the only clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a division; sampled only in IDLE.
- `is_signed` input 1: 1 selects two's-complement division, 0 selects unsigned; captured with `start`.
- `dividend` input WIDTH: numerator; captured with `start`.
- `divisor` input WIDTH: denominator; captured with `start`.
- `busy` output 1: high while iterating (RUN state).
- `done` output 1: one-cycle pulse when results update.
- `quotient` output WIDTH: registered result, held until the next completion.
- `remainder` output WIDTH: registered result, held until the next completion.
- `div_by_zero` output 1: registered flag, updated with the results.

## Operation
- States and transitions:
  - IDLE: `start` = 1 → RUN.
  - RUN: cycles WIDTH times, then → DONE.
  - DONE: one cycle, then → IDLE.
- On `start` in IDLE:
  - Latch the magnitude of each operand. In signed mode a negative operand is negated; in unsigned mode it is taken as-is.
  - Latch the result signs: quotient negative = sign(dividend) XOR sign(divisor); remainder negative = sign(dividend). Both apply only when `is_signed` = 1.
  - Latch `divisor == 0`.
  - Clear the partial remainder (WIDTH+1 bits).
  - Load the iteration counter with WIDTH.
- Each RUN cycle performs one restoring step:
  - Shift the top dividend bit into the partial remainder.
  - Trial subtract: partial remainder − divisor magnitude, at WIDTH+1 bits.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. On the cycle the counter reaches 0, go to DONE.
- Entering DONE registers the results:
  - `quotient` = magnitude quotient, negated if the quotient sign is negative.
  - `remainder` = magnitude remainder, negated if the remainder sign is negative.
  - `div_by_zero` = latched zero flag.
- Division by zero runs the full latency, with no early exit:
  - `quotient` = all ones.
  - `remainder` = original `dividend`, in both signed and unsigned modes.
  - `div_by_zero` = 1.
- Signed overflow: −2^(WIDTH−1) / −1 gives `quotient` = −2^(WIDTH−1) (wraps) and `remainder` = 0; `div_by_zero` = 0.
- Remainder sign follows the dividend; the quotient truncates toward zero.
- `start` in RUN or DONE is ignored; it is not queued.
- Operand inputs may change freely after the `start` cycle.

## Timing
- Reset values:
  - State = IDLE.
  - `busy` = 0, `done` = 0.
  - `quotient` = 0, `remainder` = 0, `div_by_zero` = 0.
  - Internal counter and registers = 0.
- Cycle numbering, with `start` sampled at edge 0:
  - `busy` = 1 after edges 0 through WIDTH−1.
  - After edge WIDTH: `busy` = 0, `done` = 1, outputs valid.
  - After edge WIDTH+1: `done` = 0, state = IDLE.
- Latency from the `start` edge to valid results is WIDTH+1 edges (33 for WIDTH = 32).
- Back-to-back operations: a new `start` is accepted at the edge after `done` falls, giving a minimum issue interval of WIDTH+2 cycles.
- `start` held high continuously re-issues with the operands present at each acceptance.
- `rst` asserted in any state, including mid-RUN, aborts the operation. At the next edge all outputs return to their reset values and no `done` is produced.
- `busy` and `done` are never high in the same cycle.

## Test plan
- Unsigned, WIDTH = 32, dividend 100, divisor 7 → after 33 edges: `done` pulse, `quotient` = 14, `remainder` = 2, `div_by_zero` = 0; `busy` high for exactly 32 cycles.
- Signed −7 / 2 → `quotient` = −3 (0xFFFFFFFD), `remainder` = −1. Signed 7 / −2 → `quotient` = −3, `remainder` = 1. Unsigned 0xFFFFFFF9 / 2 → `quotient` = 0x7FFFFFFC, `remainder` = 1.
- Divisor 0, dividend 0x1234 (both modes) → `quotient` = 0xFFFFFFFF, `remainder` = 0x1234, `div_by_zero` = 1; latency still 33 edges.
- Signed 0x80000000 / 0xFFFFFFFF → `quotient` = 0x80000000, `remainder` = 0, `div_by_zero` = 0.
- Handshake:
  - Pulse `start` mid-RUN with different operands → ignored; results match the first operation.
  - Change the operands after the `start` cycle → no effect on the results.
  - Back-to-back: hold `start` high → second `done` exactly 34 edges after the first.
- Assert `rst` at RUN cycle 10 → next cycle: `busy` = 0, all outputs 0, no `done`. A new `start` 5 / 5 then yields `quotient` = 1, `remainder` = 0.
